// File: rtl/trade_executor_if.sv
// Order handshake between the trade executor and the order/LED display stage.
// An order transfers on a cycle where order_valid and order_ready are both high; side and price hold while valid waits.
interface trade_executor_if;
    logic       order_valid;
    logic       order_side;
    logic [7:0] order_price;
    logic       order_ready;

    modport master (
        output order_valid,
        output order_side,
        output order_price,
        input  order_ready
    );

    modport slave (
        input  order_valid,
        input  order_side,
        input  order_price,
        output order_ready
    );
endinterface

// File: rtl/trade_executor.sv
// Confirms persistent BUY/SELL levels, issues one order per confirmation over a
// valid/ready handshake, tracks signed net position and enforces a post-trade cooldown.
module trade_executor #(
    parameter int CONFIRM_CYCLES  = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int MAX_POS         = 3,
    parameter int POS_W           = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    buy_sig,
    input  logic                    sell_sig,
    input  logic [7:0]              price_in,
    trade_executor_if.master        order,
    output logic signed [POS_W-1:0] position,
    output logic [7:0]              order_count,
    output logic                    conflict,
    output logic                    busy,
    output logic [1:0]              fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIRM  = 2'd1,
        ISSUE    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
    localparam int CD_W  = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [CNT_W-1:0]        CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CD_W-1:0]         CD_LOAD      = CD_W'(COOLDOWN_CYCLES);
    localparam logic signed [POS_W-1:0] POS_MAX      = POS_W'(MAX_POS);
    localparam logic signed [POS_W-1:0] POS_MIN      = -POS_MAX;
    localparam logic signed [POS_W-1:0] POS_ONE      = POS_W'(1);

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [CD_W-1:0]         cd, cd_n;
    logic                    side_q, side_n;
    logic [7:0]              price_q, price_n;
    logic signed [POS_W-1:0] pos_n;
    logic [7:0]              count_n;
    logic                    conflict_n;

    logic qual_buy, qual_sell, qual_latched;

    // The limit is checked on every sample, so a run of samples can never push position past the bounds.
    assign qual_buy     = enable & buy_sig & ~sell_sig & (position < POS_MAX);
    assign qual_sell    = enable & sell_sig & ~buy_sig & (position > POS_MIN);
    assign qual_latched = side_q ? qual_buy : qual_sell;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cd_n       = cd;
        side_n     = side_q;
        price_n    = price_q;
        pos_n      = position;
        count_n    = order_count;
        conflict_n = conflict | (buy_sig & sell_sig);

        case (state)
            IDLE: begin
                if (qual_buy | qual_sell) begin
                    side_n  = qual_buy;
                    cnt_n   = CNT_W'(1);
                    state_n = CONFIRM;
                end
            end
            CONFIRM: begin
                if (qual_latched) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt_n == CONFIRM_LAST) begin
                        price_n = price_in;
                        state_n = ISSUE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (order.order_ready) begin
                    pos_n   = side_q ? (position + POS_ONE) : (position - POS_ONE);
                    count_n = order_count + 8'd1;
                    cd_n    = CD_LOAD;
                    state_n = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (cd == CD_W'(1)) begin
                    state_n = IDLE;
                end else begin
                    cd_n = cd - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cd          <= '0;
            side_q      <= 1'b0;
            price_q     <= 8'd0;
            position    <= '0;
            order_count <= 8'd0;
            conflict    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cd          <= cd_n;
            side_q      <= side_n;
            price_q     <= price_n;
            position    <= pos_n;
            order_count <= count_n;
            conflict    <= conflict_n;
        end
    end

    // Valid is decoded from state so an asynchronous reset retracts it at once.
    assign order.order_valid = (state == ISSUE);
    assign order.order_side  = side_q;
    assign order.order_price = price_q;
    assign busy              = (state != IDLE);
    assign fsm_state         = state;

endmodule

// File: tb/tb_trade_executor.sv
// Bench for trade_executor: reset checks, a vector table, hand-written corner
// sequences and a randomized run against a cycle-indexed reference model.
module tb_trade_executor;

    localparam int CONFIRM_CYCLES  = 4;
    localparam int COOLDOWN_CYCLES = 8;
    localparam int MAX_POS         = 3;
    localparam int POS_W           = 4;

    logic                    clk      = 1'b0;
    logic                    rst_n    = 1'b0;
    logic                    enable   = 1'b0;
    logic                    buy_sig  = 1'b0;
    logic                    sell_sig = 1'b0;
    logic [7:0]              price_in = 8'd0;
    logic signed [POS_W-1:0] position;
    logic [7:0]              order_count;
    logic                    conflict;
    logic                    busy;
    logic [1:0]              fsm_state;

    trade_executor_if ord();

    trade_executor #(
        .CONFIRM_CYCLES (CONFIRM_CYCLES),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
        .MAX_POS        (MAX_POS),
        .POS_W          (POS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .buy_sig    (buy_sig),
        .sell_sig   (sell_sig),
        .price_in   (price_in),
        .order      (ord),
        .position   (position),
        .order_count(order_count),
        .conflict   (conflict),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit en, input bit b, input bit s, input logic [7:0] p, input bit r);
        enable          = en;
        buy_sig         = b;
        sell_sig        = s;
        price_in        = p;
        ord.order_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 8'd0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(ord.order_valid), 0);
        check({tag, "_side"},  int'(ord.order_side), 0);
        check({tag, "_price"}, int'(ord.order_price), 0);
        check({tag, "_pos"},   int'(position), 0);
        check({tag, "_count"}, int'(order_count), 0);
        check({tag, "_conf"},  int'(conflict), 0);
        check({tag, "_busy"},  int'(busy), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         en, b, s;
        logic [7:0] p;
        bit         r;
        bit         ev;
        bit         eside;
        logic [7:0] eprice;
        bit         ebusy;
        int         epos;
        int         ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit en, bit b, bit s, logic [7:0] p, bit r,
                                bit ev, bit eside, logic [7:0] eprice, bit ebusy, int epos, int ecnt);
        vec_t v;
        v.en = en; v.b = b; v.s = s; v.p = p; v.r = r;
        v.ev = ev; v.eside = eside; v.eprice = eprice; v.ebusy = ebusy; v.epos = epos; v.ecnt = ecnt;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Tracks the current qualifying streak, a pending order, and the first
    // cycle number at which samples are looked at again after a trade.
    int         cyc;
    int         m_streak_len;
    bit         m_streak_buy;
    bit         m_pend;
    bit         m_side;
    logic [7:0] m_price;
    int         m_pos;
    int         m_cnt;
    bit         m_conf;
    int         m_free_at;

    task automatic model_reset();
        cyc = 0; m_streak_len = 0; m_streak_buy = 0; m_pend = 0; m_side = 0;
        m_price = 8'd0; m_pos = 0; m_cnt = 0; m_conf = 0; m_free_at = 0;
    endtask

    task automatic model_step(input bit en, input bit b, input bit s, input logic [7:0] p, input bit r);
        bit q_buy, q_sell, q_same;
        if (b && s) m_conf = 1;
        if (m_pend) begin
            if (r) begin
                m_pos     = m_pos + (m_side ? 1 : -1);
                m_cnt     = (m_cnt + 1) % 256;
                m_pend    = 0;
                m_free_at = cyc + 1 + COOLDOWN_CYCLES;
            end
        end else if (cyc >= m_free_at) begin
            q_buy  = en && b && !s && (m_pos < MAX_POS);
            q_sell = en && s && !b && (m_pos > -MAX_POS);
            if (m_streak_len > 0) begin
                q_same = m_streak_buy ? q_buy : q_sell;
                if (q_same) begin
                    m_streak_len++;
                    if (m_streak_len == CONFIRM_CYCLES) begin
                        m_pend       = 1;
                        m_side       = m_streak_buy;
                        m_price      = p;
                        m_streak_len = 0;
                    end
                end else begin
                    m_streak_len = 0;
                end
            end else if (q_buy || q_sell) begin
                m_streak_len = 1;
                m_streak_buy = q_buy;
            end
        end
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         en, b, s, r;
        logic [7:0] p;
        int         mode;

        ord.order_ready = 1'b0;

        // ---- reset state ----
        #1;
        check_all_zero("reset");
        check("reset_state", int'(fsm_state), 0);
        tick();
        rst_n = 1'b1;

        // ---- table: basic BUY then SELL glitch reject ----
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 8'h40, 1, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h40, 1, 1, 1, 8'h40, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h40, 1, 0, 0, 8'h00, 1, 1, 1));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 1, 0, 8'h40, 1, 0, 0, 8'h00, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h40, 1, 0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h40, 1, 0, 0, 8'h00, 0, 1, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 1, 8'h22, 1, 0, 0, 8'h00, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 8'h22, 1, 0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 8'h22, 1, 0, 0, 8'h00, 0, 1, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].b, vecs[i].s, vecs[i].p, vecs[i].r);
            tick();
            check($sformatf("vec%0d_valid", i), int'(ord.order_valid), int'(vecs[i].ev));
            check($sformatf("vec%0d_busy", i),  int'(busy), int'(vecs[i].ebusy));
            check($sformatf("vec%0d_pos", i),   int'(position), vecs[i].epos);
            check($sformatf("vec%0d_count", i), int'(order_count), vecs[i].ecnt);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_side", i),  int'(ord.order_side), int'(vecs[i].eside));
                check($sformatf("vec%0d_price", i), int'(ord.order_price), int'(vecs[i].eprice));
            end
        end

        // ---- backpressure ----
        do_reset();
        repeat (4) begin drive(1, 1, 0, 8'h40, 0); tick(); end
        check("bp_valid_first", int'(ord.order_valid), 1);
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 0, 1, 8'h55, 0);
            tick();
            check("bp_hold_valid", int'(ord.order_valid), 1);
            check("bp_hold_price", int'(ord.order_price), 8'h40);
            check("bp_hold_side",  int'(ord.order_side), 1);
            check("bp_hold_pos",   int'(position), 0);
        end
        drive(0, 0, 0, 8'h55, 1);
        tick();
        check("bp_accept_valid", int'(ord.order_valid), 0);
        check("bp_accept_pos",   int'(position), 1);
        check("bp_accept_count", int'(order_count), 1);
        tick();
        check("bp_single_count", int'(order_count), 1);

        // ---- position limit ----
        do_reset();
        repeat (45) begin drive(1, 1, 0, 8'(($urandom_range(0, 255))), 1); tick(); end
        check("lim_pos",   int'(position), 3);
        check("lim_count", int'(order_count), 3);
        check("lim_busy",  int'(busy), 0);
        repeat (5) begin
            tick();
            check("lim_no_confirm", int'(busy), 0);
        end
        repeat (5) begin drive(1, 0, 1, 8'h10, 1); tick(); end
        check("lim_sell_pos",   int'(position), 2);
        check("lim_sell_count", int'(order_count), 4);

        // ---- conflict ----
        do_reset();
        check("conf_clear", int'(conflict), 0);
        repeat (2) begin drive(1, 1, 0, 8'h30, 0); tick(); end
        check("conf_confirming", int'(busy), 1);
        drive(1, 1, 1, 8'h30, 0);
        tick();
        check("conf_abort_busy", int'(busy), 0);
        check("conf_set",        int'(conflict), 1);
        repeat (3) begin drive(0, 0, 0, 8'h30, 0); tick(); end
        check("conf_sticky", int'(conflict), 1);
        check("conf_no_order", int'(ord.order_valid), 0);
        rst_n = 1'b0;
        #1;
        check("conf_reset", int'(conflict), 0);
        tick();
        rst_n = 1'b1;

        // ---- reset mid-ISSUE ----
        do_reset();
        repeat (13) begin drive(1, 1, 0, 8'h61, 1); tick(); end
        check("rmi_pre_pos", int'(position), 1);
        repeat (4) begin drive(1, 1, 0, 8'h62, 0); tick(); end
        check("rmi_valid", int'(ord.order_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rmi_async");
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 8'h00, 0);
        tick();
        check("rmi_idle", int'(fsm_state), 0);
        check("rmi_pos",  int'(position), 0);

        // ---- randomized against the reference model ----
        do_reset();
        model_reset();
        mode = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                mode = $urandom_range(0, 31);
            end
            b  = (mode == 0) || (mode >= 1 && mode <= 11);
            s  = (mode == 0) || (mode >= 12 && mode <= 22);
            en = ($urandom_range(0, 15) != 0);
            r  = ($urandom_range(0, 2) != 0);
            p  = 8'($urandom_range(0, 255));
            drive(en, b, s, p, r);
            model_step(en, b, s, p, r);
            tick();
            check("rnd_valid", int'(ord.order_valid), int'(m_pend));
            check("rnd_busy",  int'(busy), int'(m_pend || (m_streak_len > 0) || (cyc < m_free_at)));
            check("rnd_pos",   int'(position), m_pos);
            check("rnd_count", int'(order_count), m_cnt);
            check("rnd_conf",  int'(conflict), int'(m_conf));
            if (m_pend) begin
                check("rnd_side",  int'(ord.order_side), int'(m_side));
                check("rnd_price", int'(ord.order_price), int'(m_price));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trade_executor.md
Name: trade_executor

Overview:
- Downstream consumer of the price-vs-threshold comparator's BUY/SELL level signals.
- Requires a signal to persist before acting, then issues one order through a valid/ready handshake and tracks net position.
- Enforces position limits and a post-trade cooldown.
- Outputs feed the order/LED display stage.

Parameters:
- CONFIRM_CYCLES, 4: consecutive qualifying samples needed before an order is issued; legal range is 2 or more.
- COOLDOWN_CYCLES, 8: cycles after an accepted order during which signals are ignored; legal range is 1 or more.
- MAX_POS, 3: position limit, so position stays within -MAX_POS..+MAX_POS.
- POS_W, 4: width of the signed position output; must hold ±MAX_POS.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  arms the executor; low blocks new trades.
- buy_sig  in  1  BUY level from the comparator (price < threshold).
- sell_sig  in  1  SELL level from the comparator (price > threshold).
- price_in  in  8  current price, unsigned.
- order_valid  out  1  order presented.
- order_side  out  1  1 = BUY, 0 = SELL; valid while order_valid is high.
- order_price  out  8  price captured at confirmation.
- order_ready  in  1  downstream accepts the order.
- position  out  POS_W  signed net position.
- order_count  out  8  accepted orders, wraps 255 to 0.
- conflict  out  1  sticky flag: buy_sig and sell_sig seen high together.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state is IDLE.
  - order_valid, order_side, order_price, position, order_count, conflict and busy are all 0.
  - Reset asserted mid-ISSUE drops order_valid immediately and the order is lost.
- Qualifying sample for side S: enable=1, the S signal is 1, the other signal is 0, and the position limit allows S.
  - BUY is allowed only if position < MAX_POS.
  - SELL is allowed only if position > -MAX_POS.
- FSM has four states: IDLE, CONFIRM, ISSUE, COOLDOWN.
  - IDLE: on a qualifying sample, latch side S, set cnt=1, go to CONFIRM. Otherwise stay in IDLE.
  - CONFIRM: on a qualifying sample for the latched S, increment cnt.
    - When the incremented cnt equals CONFIRM_CYCLES: register order_price <= price_in from that same sample and go to ISSUE.
    - Any non-qualifying sample (signal drop, opposite side, both high, enable low, limit reached): return to IDLE with no order. The next cycle can start a new confirmation.
  - ISSUE: order_valid=1, with order_side and order_price held stable until acceptance.
    - Handshake completes on a cycle with order_valid and order_ready both high.
    - On completion: position updates by ±1, order_count increments, go to COOLDOWN with cd=COOLDOWN_CYCLES.
    - order_valid falls on the next cycle.
    - enable or input signals changing during ISSUE do not retract the order. Wait for ready is unbounded.
  - COOLDOWN: decrement cd every cycle; go to IDLE on the cycle after cd reaches 1. Inputs are ignored except for conflict detection.
- Latency: with signals stable from cycle 0, order_valid is first high in cycle CONFIRM_CYCLES.
- Conflict flag: conflict is set when buy_sig=1 and sell_sig=1 in any state. It is cleared only by reset.
- Position arithmetic: signed two's complement. It can never exceed ±MAX_POS because the limit is checked at every qualifying sample.
- order_count is 8-bit, modulo 256.
- busy = (state != IDLE).

Test Plan:
- Basic BUY: enable=1, buy_sig=1 for cycles 0–3, price_in=0x40 → order_valid=1 from cycle 4, side=1, price=0x40. With ready=1 at cycle 4: position=1 and order_count=1 at cycle 5; busy high until cooldown ends (cycle 13).
- Glitch reject: sell_sig high for 3 cycles then low → no order_valid, position stays 0, FSM back in IDLE.
- Backpressure: BUY confirmed, order_ready held 0 for 10 cycles while price_in changes to 0x55 → order_valid stays high and order_price stays 0x40; ready=1 → single acceptance, position=+1.
- Position limit: four back-to-back confirmed BUYs with ready=1 → position saturates at 3; the fourth confirmation is never entered (busy low). A SELL then proceeds → position=2.
- Conflict: buy_sig and sell_sig both high in CONFIRM → return to IDLE, conflict=1; conflict persists after the inputs clear until rst_n=0.
- Reset mid-ISSUE: rst_n pulsed low while order_valid=1 → all outputs 0 immediately (asynchronous); after release, state is IDLE and position=0.
